// File: rtl/mecobo_sched_pkg.sv
// Shared definitions for the timed command scheduler: FSM states, opcodes
// and the bit positions of the fields inside a packed command word.
package mecobo_sched_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    WAIT_VALID = 3'd2,
    HOLD       = 3'd3,
    ISSUE      = 3'd4
  } sched_state_t;

  typedef enum logic [1:0] {
    OP_WRITE      = 2'b00,
    OP_RESET_TIME = 2'b01,
    OP_BROADCAST  = 2'b10,
    OP_INVALID    = 2'b11
  } sched_op_t;

  localparam int unsigned OP_W = 2;

  // Command word is {timestamp, opcode, addr, data}, MSB first.
  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned op_lsb(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w;
  endfunction

  function automatic int unsigned ts_lsb(input int unsigned addr_w, input int unsigned data_w);
    return addr_w + data_w + OP_W;
  endfunction

endpackage

// File: rtl/timed_cmd_scheduler_chan_decode.sv
// Channel index to one-hot select, with broadcast override and an
// out-of-range flag for indices beyond the implemented channel count.
module chan_decode #(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned IDX_W        = 8
) (
  input  logic [IDX_W-1:0]        idx,
  input  logic                    broadcast,
  output logic [NUM_CHANNELS-1:0] onehot,
  output logic                    out_of_range
);

  localparam int unsigned CW = (IDX_W > 32) ? IDX_W : 32;

  logic [CW-1:0] idx_w;
  assign idx_w = CW'(idx);

  always_comb begin
    onehot       = '0;
    out_of_range = (idx_w >= CW'(NUM_CHANNELS));
    if (broadcast) begin
      onehot = '1;
    end else begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        onehot[i] = (idx_w == CW'(i));
      end
    end
  end

endmodule

// File: rtl/timed_cmd_scheduler.sv
// Pops timestamped commands from a FIFO, holds each until global time reaches
// its timestamp, then issues it on the command bus as a one-cycle strobe.
module timed_cmd_scheduler
  import mecobo_sched_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 16,
  parameter int unsigned TIME_W       = 32,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned CH_SHIFT     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   halt,
  input  logic [TIME_W+OP_W+ADDR_W+DATA_W-1:0]   cmd_fifo_dout,
  input  logic                                   cmd_fifo_empty,
  input  logic                                   cmd_fifo_valid,
  output logic                                   cmd_fifo_rd_en,
  output logic [TIME_W-1:0]                      current_time,
  output logic [ADDR_W-1:0]                      cmd_bus_addr,
  output logic [DATA_W-1:0]                      cmd_bus_data,
  output logic                                   cmd_bus_en,
  output logic                                   cmd_bus_wr,
  output logic [NUM_CHANNELS-1:0]                chan_sel,
  output logic [15:0]                            late_count,
  output logic [15:0]                            err_count,
  output logic                                   busy
);

  localparam int unsigned CMD_W    = TIME_W + OP_W + ADDR_W + DATA_W;
  localparam int unsigned ADDR_LSB = addr_lsb(DATA_W);
  localparam int unsigned OP_LSB   = op_lsb(ADDR_W, DATA_W);
  localparam int unsigned TS_LSB   = ts_lsb(ADDR_W, DATA_W);

  sched_state_t state, state_nxt;

  logic [CMD_W-1:0]        cmd_q;
  logic                    hold_first;
  logic [TIME_W-1:0]       cmd_ts;
  sched_op_t               cmd_op;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [DATA_W-1:0]       cmd_data;
  logic [NUM_CHANNELS-1:0] dec_sel;
  logic                    dec_oor;
  logic                    time_reached;
  logic                    drive_bus;
  logic                    drop_cmd;

  assign cmd_ts   = cmd_q[TS_LSB +: TIME_W];
  assign cmd_op   = sched_op_t'(cmd_q[OP_LSB +: OP_W]);
  assign cmd_addr = cmd_q[ADDR_LSB +: ADDR_W];
  assign cmd_data = cmd_q[DATA_W-1:0];

  assign time_reached = (current_time >= cmd_ts);
  assign drive_bus    = (cmd_op == OP_BROADCAST) || (cmd_op == OP_WRITE && !dec_oor);
  assign drop_cmd     = (cmd_op == OP_INVALID)   || (cmd_op == OP_WRITE && dec_oor);

  chan_decode #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (ADDR_W - CH_SHIFT)
  ) u_chan_decode (
    .idx          (cmd_addr[ADDR_W-1:CH_SHIFT]),
    .broadcast    (cmd_op == OP_BROADCAST),
    .onehot       (dec_sel),
    .out_of_range (dec_oor)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cmd_fifo_rd_en = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE:       if (!cmd_fifo_empty && !halt) state_nxt = FETCH;
      FETCH: begin
        cmd_fifo_rd_en = 1'b1;
        state_nxt      = WAIT_VALID;
      end
      WAIT_VALID: if (cmd_fifo_valid) state_nxt = HOLD;
      HOLD:       if (time_reached) state_nxt = ISSUE;
      ISSUE:      state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Bus outputs are registered on the HOLD->ISSUE edge so they are valid
  // exactly during the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_time <= '0;
      cmd_q        <= '0;
      hold_first   <= 1'b0;
      cmd_bus_addr <= '0;
      cmd_bus_data <= '0;
      cmd_bus_en   <= 1'b0;
      cmd_bus_wr   <= 1'b0;
      chan_sel     <= '0;
      late_count   <= '0;
      err_count    <= '0;
    end else begin
      cmd_bus_en <= 1'b0;
      cmd_bus_wr <= 1'b0;
      chan_sel   <= '0;
      hold_first <= 1'b0;

      if (state == ISSUE && cmd_op == OP_RESET_TIME) current_time <= '0;
      else                                           current_time <= current_time + TIME_W'(1);

      if (state == WAIT_VALID && cmd_fifo_valid) begin
        cmd_q      <= cmd_fifo_dout;
        hold_first <= 1'b1;
      end

      if (state == HOLD && hold_first && current_time > cmd_ts && late_count != '1)
        late_count <= late_count + 16'd1;

      if (state == HOLD && time_reached) begin
        cmd_bus_addr <= cmd_addr;
        cmd_bus_data <= cmd_data;
        if (drive_bus) begin
          cmd_bus_en <= 1'b1;
          cmd_bus_wr <= 1'b1;
          chan_sel   <= dec_sel;
        end
        if (drop_cmd && err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
